// File: rtl/snax_alu_pe_acc_if.sv
// Stream bundle for snax_alu_pe_acc: A/B operand streams, C result stream and group config.
// slave is the PE's view, master is the streamer/driver view.
interface snax_alu_pe_acc_if #(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned CntWidth  = 8
);
    logic [DataWidth-1:0] a_i;
    logic                 a_valid_i;
    logic                 a_ready_o;
    logic [DataWidth-1:0] b_i;
    logic                 b_valid_i;
    logic                 b_ready_o;
    logic [DataWidth-1:0] c_o;
    logic                 c_valid_o;
    logic                 c_ready_i;
    logic [2:0]           alu_config_i;
    logic                 acc_en_i;
    logic [CntWidth-1:0]  acc_len_i;
    logic                 busy_o;

    modport slave (
        input  a_i, a_valid_i, b_i, b_valid_i, c_ready_i,
        input  alu_config_i, acc_en_i, acc_len_i,
        output a_ready_o, b_ready_o, c_o, c_valid_o, busy_o
    );

    modport master (
        output a_i, a_valid_i, b_i, b_valid_i, c_ready_i,
        output alu_config_i, acc_en_i, acc_len_i,
        input  a_ready_o, b_ready_o, c_o, c_valid_o, busy_o
    );
endinterface

// File: rtl/snax_alu_pe_acc.sv
// Joined A/B ALU PE with registered result and in-PE group accumulation (SNAX_ALU_PE_SAT_EN: saturating add/sub/acc).
// Latency: result valid 1 cycle after the fire (element) or after the last fire of a group (accumulate).
// Backpressure: a held result (c_valid_o && !c_ready_i) blocks the join; A and B are consumed together.
module snax_alu_pe_acc #(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned CntWidth  = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    snax_alu_pe_acc_if.slave io
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ACCUM = 1'b1;

    localparam logic [CntWidth-1:0] CntOne = {{(CntWidth-1){1'b0}}, 1'b1};

    logic [DataWidth-1:0] c_q, c_d;
    logic                 c_valid_q, c_valid_d;
    logic [DataWidth-1:0] acc_q, acc_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic [2:0]           op_q, op_d;
    logic [CntWidth-1:0]  len_q, len_d;

    logic [0:0]           state;
    logic                 fire;
    logic [2:0]           op_sel;
    logic [DataWidth-1:0] res;
    logic [DataWidth-1:0] acc_sum;
    logic [CntWidth-1:0]  len_in;
    logic [CntWidth-1:0]  cnt_inc;

    function automatic logic [DataWidth-1:0] add_fn(
        input logic [DataWidth-1:0] x,
        input logic [DataWidth-1:0] y,
        input logic                 sub
    );
`ifdef SNAX_ALU_PE_SAT_EN
        logic [DataWidth:0] xe;
        logic [DataWidth:0] ye;
        logic [DataWidth:0] s;
        xe = {x[DataWidth-1], x};
        ye = {y[DataWidth-1], y};
        s  = sub ? (xe - ye) : (xe + ye);
        // Overflow when the true sign bit disagrees with the truncated sign bit.
        if (s[DataWidth] != s[DataWidth-1]) begin
            return s[DataWidth] ? {1'b1, {(DataWidth-1){1'b0}}}
                                : {1'b0, {(DataWidth-1){1'b1}}};
        end
        return s[DataWidth-1:0];
`else
        return sub ? (x - y) : (x + y);
`endif
    endfunction

    assign state = (cnt_q != '0) ? ST_ACCUM : ST_IDLE;
    assign fire  = io.a_valid_i && io.b_valid_i && (!c_valid_q || io.c_ready_i);

    always_comb begin
        op_sel = (state == ST_ACCUM) ? op_q : io.alu_config_i;
        res    = '0;
        case (op_sel)
            3'd0:    res = add_fn(io.a_i, io.b_i, 1'b0);
            3'd1:    res = add_fn(io.a_i, io.b_i, 1'b1);
            3'd2:    res = io.a_i * io.b_i;
            3'd3:    res = io.a_i ^ io.b_i;
            3'd4:    res = io.a_i & io.b_i;
            3'd5:    res = io.a_i | io.b_i;
            3'd6:    res = ($signed(io.a_i) < $signed(io.b_i)) ? io.a_i : io.b_i;
            default: res = ($signed(io.a_i) > $signed(io.b_i)) ? io.a_i : io.b_i;
        endcase
    end

    always_comb begin
        len_in    = (io.acc_len_i == '0) ? CntOne : io.acc_len_i;
        cnt_inc   = cnt_q + CntOne;
        acc_sum   = add_fn(acc_q, res, 1'b0);

        c_d       = c_q;
        c_valid_d = c_valid_q && !io.c_ready_i;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        len_d     = len_q;

        if (fire) begin
            if (state == ST_IDLE) begin
                // A group of length 1 is indistinguishable from element mode.
                if (io.acc_en_i && (len_in != CntOne)) begin
                    acc_d = res;
                    cnt_d = CntOne;
                    op_d  = io.alu_config_i;
                    len_d = len_in;
                end else begin
                    c_d       = res;
                    c_valid_d = 1'b1;
                end
            end else begin
                acc_d = acc_sum;
                if (cnt_inc == len_q) begin
                    c_d       = acc_sum;
                    c_valid_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            c_q       <= '0;
            c_valid_q <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            op_q      <= '0;
            len_q     <= '0;
        end else begin
            c_q       <= c_d;
            c_valid_q <= c_valid_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            len_q     <= len_d;
        end
    end

    assign io.c_o       = c_q;
    assign io.c_valid_o = c_valid_q;
    assign io.a_ready_o = fire;
    assign io.b_ready_o = fire;
    assign io.busy_o    = (state == ST_ACCUM);

endmodule

// File: tb/tb_snax_alu_pe_acc.sv
// Bench for snax_alu_pe_acc: directed table/sequences on a 64-bit PE, an 8-bit PE for overflow, random vs reference model.
module tb_snax_alu_pe_acc;

    logic clk_i;
    logic rst_i;

    snax_alu_pe_acc_if #(.DataWidth(64), .CntWidth(8)) bus ();
    snax_alu_pe_acc_if #(.DataWidth(8),  .CntWidth(8)) bus8 ();

    snax_alu_pe_acc #(.DataWidth(64), .CntWidth(8)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .io    (bus)
    );

    snax_alu_pe_acc #(.DataWidth(8), .CntWidth(8)) dut8 (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .io    (bus8)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[8];

    // Reference model: pending output register plus remaining elements of the open group.
    logic        m_valid;
    logic [63:0] m_val;
    int          m_left;
    logic [2:0]  m_op;
    logic [63:0] m_sum;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    function automatic logic [63:0] m_add(input logic [63:0] x, input logic [63:0] y, input logic sub);
`ifdef SNAX_ALU_PE_SAT_EN
        logic signed [65:0] s;
        s = sub ? ($signed({{2{x[63]}}, x}) - $signed({{2{y[63]}}, y}))
                : ($signed({{2{x[63]}}, x}) + $signed({{2{y[63]}}, y}));
        if (s > 66'sd9223372036854775807) return 64'h7FFF_FFFF_FFFF_FFFF;
        if (s < -66'sd9223372036854775808) return 64'h8000_0000_0000_0000;
        return s[63:0];
`else
        return sub ? (x - y) : (x + y);
`endif
    endfunction

    function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [63:0] x, input logic [63:0] y);
        case (op)
            3'd0:    return m_add(x, y, 1'b0);
            3'd1:    return m_add(x, y, 1'b1);
            3'd2:    return x * y;
            3'd3:    return x ^ y;
            3'd4:    return x & y;
            3'd5:    return x | y;
            3'd6:    return ($signed(x) < $signed(y)) ? x : y;
            default: return ($signed(x) > $signed(y)) ? x : y;
        endcase
    endfunction

    function automatic logic [63:0] rnd_operand();
        case ($urandom_range(0, 3))
            0:       return {$urandom, $urandom};
            1:       return 64'($urandom_range(0, 20));
            2:       return -64'($urandom_range(0, 20));
            default: return 64'h7FFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin
        logic        exp_rdy;
        logic [63:0] v;
        int          len;

        vecs[0] = '{"add",  3'd0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd4, 64'd1};
        vecs[1] = '{"sub",  3'd1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd4, 64'hFFFF_FFFF_FFFF_FFF9};
        vecs[2] = '{"mul",  3'd2, 64'hFFFF_FFFF_FFFF_FFFD, 64'd4, 64'hFFFF_FFFF_FFFF_FFF4};
        vecs[3] = '{"xor",  3'd3, 64'hFFFF_FFFF_FFFF_FFFD, 64'd4, 64'hFFFF_FFFF_FFFF_FFF9};
        vecs[4] = '{"and",  3'd4, 64'hFFFF_FFFF_FFFF_FFFD, 64'd4, 64'd4};
        vecs[5] = '{"or",   3'd5, 64'hFFFF_FFFF_FFFF_FFFD, 64'd4, 64'hFFFF_FFFF_FFFF_FFFD};
        vecs[6] = '{"min",  3'd6, 64'hFFFF_FFFF_FFFF_FFFD, 64'd4, 64'hFFFF_FFFF_FFFF_FFFD};
        vecs[7] = '{"max",  3'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'd4, 64'd4};

        bus.a_i = '0; bus.a_valid_i = 1'b0; bus.b_i = '0; bus.b_valid_i = 1'b0;
        bus.c_ready_i = 1'b1; bus.alu_config_i = 3'd0; bus.acc_en_i = 1'b0; bus.acc_len_i = '0;
        bus8.a_i = '0; bus8.a_valid_i = 1'b0; bus8.b_i = '0; bus8.b_valid_i = 1'b0;
        bus8.c_ready_i = 1'b1; bus8.alu_config_i = 3'd0; bus8.acc_en_i = 1'b0; bus8.acc_len_i = '0;

        rst_i = 1'b1;
        tick();
        tick();
        chk("rst_c_valid", bus.c_valid_o, 0);
        chk("rst_c", bus.c_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_a_ready", bus.a_ready_o, 0);
        rst_i = 1'b0;
        tick();

        // Back-to-back element adds.
        bus.a_i = 64'd5; bus.b_i = 64'd7; bus.a_valid_i = 1'b1; bus.b_valid_i = 1'b1;
        #1;
        chk("join_a_ready", bus.a_ready_o, 1);
        chk("join_b_ready", bus.b_ready_o, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("elem_valid", bus.c_valid_o, 1);
            chk("elem_add", bus.c_o, 64'd12);
        end
        bus.a_valid_i = 1'b0; bus.b_valid_i = 1'b0;
        tick();
        chk("elem_drain", bus.c_valid_o, 0);

        // Op sweep table, streamed back-to-back.
        bus.a_valid_i = 1'b1; bus.b_valid_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.alu_config_i = vecs[i].op; bus.a_i = vecs[i].a; bus.b_i = vecs[i].b;
            tick();
            chk({"op_", vecs[i].name}, bus.c_o, vecs[i].exp);
        end
        bus.a_valid_i = 1'b0; bus.b_valid_i = 1'b0; bus.alu_config_i = 3'd0;
        tick();

        // Backpressure hold then bubble-free replacement.
        bus.a_i = 64'd10; bus.b_i = 64'd1; bus.a_valid_i = 1'b1; bus.b_valid_i = 1'b1;
        tick();
        chk("bp_first", bus.c_o, 64'd11);
        bus.c_ready_i = 1'b0; bus.a_i = 64'd20; bus.b_i = 64'd2;
        #1;
        chk("bp_a_ready", bus.a_ready_o, 0);
        chk("bp_b_ready", bus.b_ready_o, 0);
        tick();
        tick();
        chk("bp_hold_valid", bus.c_valid_o, 1);
        chk("bp_hold_c", bus.c_o, 64'd11);
        bus.c_ready_i = 1'b1;
        #1;
        chk("bp_release_ready", bus.a_ready_o, 1);
        tick();
        chk("bp_next_valid", bus.c_valid_o, 1);
        chk("bp_next_c", bus.c_o, 64'd22);
        bus.a_valid_i = 1'b0; bus.b_valid_i = 1'b0;
        tick();
        chk("bp_drain", bus.c_valid_o, 0);

        // Accumulate group of 4 with config changed mid-group.
        bus.acc_en_i = 1'b1; bus.acc_len_i = 8'd4; bus.alu_config_i = 3'd0; bus.b_i = 64'd0;
        bus.a_valid_i = 1'b1; bus.b_valid_i = 1'b1;
        chk("acc_busy_pre", bus.busy_o, 0);
        for (int i = 1; i <= 4; i++) begin
            bus.a_i = 64'(i);
            if (i == 3) begin
                bus.alu_config_i = 3'd2; bus.acc_len_i = 8'd1; bus.acc_en_i = 1'b0;
            end
            tick();
            if (i < 4) begin
                chk("acc_busy_mid", bus.busy_o, 1);
                chk("acc_no_out", bus.c_valid_o, 0);
            end else begin
                chk("acc_out_valid", bus.c_valid_o, 1);
                chk("acc_sum", bus.c_o, 64'd10);
                chk("acc_busy_end", bus.busy_o, 0);
            end
        end
        bus.a_valid_i = 1'b0; bus.b_valid_i = 1'b0;
        tick();
        chk("acc_single_out", bus.c_valid_o, 0);

        // Length 0 behaves as element mode; reset drops the pending result.
        bus.alu_config_i = 3'd0; bus.acc_en_i = 1'b1; bus.acc_len_i = 8'd0;
        bus.a_i = 64'd3; bus.b_i = 64'd4; bus.a_valid_i = 1'b1; bus.b_valid_i = 1'b1;
        tick();
        chk("len0_valid", bus.c_valid_o, 1);
        chk("len0_c", bus.c_o, 64'd7);
        chk("len0_busy", bus.busy_o, 0);
        bus.a_valid_i = 1'b0; bus.b_valid_i = 1'b0; bus.c_ready_i = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("rst_drop_valid", bus.c_valid_o, 0);
        chk("rst_drop_c", bus.c_o, 0);
        bus.c_ready_i = 1'b1;

        // Reset mid-group, then a clean group.
        bus.acc_len_i = 8'd4; bus.a_i = 64'd100; bus.b_i = 64'd0;
        bus.a_valid_i = 1'b1; bus.b_valid_i = 1'b1;
        tick();
        tick();
        chk("mid_busy", bus.busy_o, 1);
        bus.a_valid_i = 1'b0; bus.b_valid_i = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("mid_rst_busy", bus.busy_o, 0);
        chk("mid_rst_valid", bus.c_valid_o, 0);
        bus.acc_len_i = 8'd2; bus.a_i = 64'd1; bus.b_i = 64'd1;
        bus.a_valid_i = 1'b1; bus.b_valid_i = 1'b1;
        tick();
        chk("clean_first_no_out", bus.c_valid_o, 0);
        tick();
        chk("clean_valid", bus.c_valid_o, 1);
        chk("clean_sum", bus.c_o, 64'd4);
        bus.a_valid_i = 1'b0; bus.b_valid_i = 1'b0; bus.acc_en_i = 1'b0;
        tick();

        // 8-bit overflow behaviour.
        bus8.a_i = 8'h7F; bus8.b_i = 8'h01; bus8.alu_config_i = 3'd0;
        bus8.a_valid_i = 1'b1; bus8.b_valid_i = 1'b1;
        tick();
`ifdef SNAX_ALU_PE_SAT_EN
        chk("w8_add_ovf", 64'(bus8.c_o), 64'h7F);
`else
        chk("w8_add_ovf", 64'(bus8.c_o), 64'h80);
`endif
        bus8.a_i = 8'h80; bus8.alu_config_i = 3'd1;
        tick();
`ifdef SNAX_ALU_PE_SAT_EN
        chk("w8_sub_ovf", 64'(bus8.c_o), 64'h80);
`else
        chk("w8_sub_ovf", 64'(bus8.c_o), 64'h7F);
`endif
        bus8.a_valid_i = 1'b0; bus8.b_valid_i = 1'b0;
        tick();

        // Random traffic against the reference model.
        m_valid = 1'b0; m_val = '0; m_left = 0; m_op = '0; m_sum = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            bus.a_valid_i    = ($urandom_range(0, 3) != 0);
            bus.b_valid_i    = ($urandom_range(0, 3) != 0);
            bus.c_ready_i    = ($urandom_range(0, 3) != 0);
            bus.a_i          = rnd_operand();
            bus.b_i          = rnd_operand();
            bus.alu_config_i = 3'($urandom_range(0, 7));
            bus.acc_en_i     = ($urandom_range(0, 1) != 0);
            bus.acc_len_i    = 8'($urandom_range(0, 4));
            #1;
            exp_rdy = bus.a_valid_i && bus.b_valid_i && (!m_valid || bus.c_ready_i);
            chk("rnd_ready", bus.a_ready_o, exp_rdy);
            if (m_valid && bus.c_ready_i) m_valid = 1'b0;
            if (exp_rdy) begin
                if (m_left == 0) begin
                    len = bus.acc_en_i ? ((bus.acc_len_i == 0) ? 1 : int'(bus.acc_len_i)) : 1;
                    m_op = bus.alu_config_i;
                    v = ref_op(m_op, bus.a_i, bus.b_i);
                    if (len == 1) begin
                        m_valid = 1'b1; m_val = v;
                    end else begin
                        m_sum = v; m_left = len - 1;
                    end
                end else begin
                    m_sum = m_add(m_sum, ref_op(m_op, bus.a_i, bus.b_i), 1'b0);
                    m_left--;
                    if (m_left == 0) begin
                        m_valid = 1'b1; m_val = m_sum;
                    end
                end
            end
            tick();
            chk("rnd_valid", bus.c_valid_o, m_valid);
            if (m_valid) chk("rnd_c", bus.c_o, m_val);
            chk("rnd_busy", bus.busy_o, m_left != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
